idct_mac_sequencer: RTL

Sequences one 8-point 1-D IDCT pass over an 8x8 coefficient block, one multiply-accumulate tap per cycle. The block generates read addresses into the block buffer and the cosine-coefficient ROM, runs a registered multiply/accumulate pipeline, and rounds and saturates each result. Each result is written back through a ready/valid write port. Two invocations make a full 2-D IDCT: mode=0 for the row pass, mode=1 for the column (transposed) pass.

---
 rtl/idct_mac_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/idct_mac_sequencer.sv
// idct_mac_sequencer
//   Sequences one 8-point 1-D IDCT pass over an 8x8 block. Each output is
//   formed from 8 multiply-accumulate taps, one tap per cycle. The result is
//   rounded, saturated and written back through a ready/valid write port.
//   mode=0 runs the row pass and mode=1 runs the column (transposed) pass.
// Ports
//   clk, rst         : clock; asynchronous active-high reset
//   start, mode      : start a pass (sampled in IDLE); pass direction, latched
//   busy, done       : pass in progress; one-cycle pulse after the last write
//   rd_en            : read strobe shared by the block buffer and the ROM
//   in_addr          : block-buffer read address
//   coef_addr        : cosine ROM read address (k*8+n)
//   in_data          : sample returned the cycle after rd_en
//   coef_data        : coefficient returned the cycle after rd_en
//   out_we           : write valid; out_ready accepts it
//   out_addr         : write address
//   out_data         : rounded, saturated result
module idct_mac_sequencer #(
  parameter int DW   = 16,
  parameter int CW   = 16,
  parameter int FRAC = 14,
  parameter int OW   = 16,
  parameter int AW   = DW + CW + 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 mode,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [5:0]           in_addr,
  output logic [5:0]           coef_addr,
  input  logic signed [DW-1:0] in_data,
  input  logic signed [CW-1:0] coef_data,
  output logic                 out_we,
  input  logic                 out_ready,
  output logic [5:0]           out_addr,
  output logic signed [OW-1:0] out_data
);

  localparam int PW = DW + CW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Rounding offset and saturation limits, held one bit wider than the
  // accumulator so the rounding add can never wrap.
  localparam logic signed [AW:0] RND_V = {{(AW-FRAC+1){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [AW:0] MAX_V = {{(AW-OW+2){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [AW:0] MIN_V = {{(AW-OW+2){1'b1}}, {(OW-1){1'b0}}};

  function automatic logic signed [OW-1:0] round_sat(input logic signed [AW-1:0] a);
    logic signed [AW:0] t;
    logic signed [AW:0] s;
    t = $signed({a[AW-1], a}) + RND_V;
    s = t >>> FRAC;
    if (s > MAX_V)      round_sat = OW'(MAX_V);
    else if (s < MIN_V) round_sat = OW'(MIN_V);
    else                round_sat = OW'(s);
  endfunction

  // Control state
  logic [2:0] state_q, state_d;
  logic [2:0] r_q, r_d;
  logic [2:0] k_q, k_d;
  logic [2:0] n_q, n_d;
  logic       mode_q, mode_d;
  logic       drain_q, drain_d;
  logic [5:0] out_addr_q, out_addr_d;

  // Datapath pipeline
  logic                 vld_p0_q, vld_p0_d;
  logic [2:0]           tap_p0_q, tap_p0_d;
  logic                 vld_p1_q, vld_p1_d;
  logic [2:0]           tap_p1_q, tap_p1_d;
  logic signed [PW-1:0] prod_p1_q, prod_p1_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [OW-1:0] out_data_q, out_data_d;

  assign busy      = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_WRITE);
  assign done      = (state_q == S_DONE);
  assign rd_en     = (state_q == S_READ);
  assign out_we    = (state_q == S_WRITE);
  // Addresses are parked at zero whenever no read is in flight.
  assign in_addr   = rd_en ? (mode_q ? {n_q, r_q} : {r_q, n_q}) : 6'd0;
  assign coef_addr = rd_en ? {k_q, n_q} : 6'd0;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    k_d        = k_q;
    n_d        = n_q;
    mode_d     = mode_q;
    drain_d    = drain_q;
    out_addr_d = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          mode_d  = mode;
          r_d     = 3'd0;
          k_d     = 3'd0;
          n_d     = 3'd0;
        end
      end
      S_READ: begin
        // n wraps back to 0 after tap 7, ready for the next output.
        n_d = n_q + 3'd1;
        if (n_q == 3'd7) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) begin
          state_d    = S_WRITE;
          out_addr_d = mode_q ? {k_q, r_q} : {r_q, k_q};
        end
      end
      S_WRITE: begin
        if (out_ready) begin
          if ((r_q == 3'd7) && (k_q == 3'd7)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
            k_d     = k_q + 3'd1;
            if (k_q == 3'd7) r_d = r_q + 3'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // p0: memory data returns one cycle after the read strobe
    vld_p0_d  = rd_en;
    tap_p0_d  = n_q;
    // p1: registered product
    vld_p1_d  = vld_p0_q;
    tap_p1_d  = tap_p0_q;
    prod_p1_d = vld_p0_q ? (PW'(in_data) * PW'(coef_data)) : prod_p1_q;
    // p2: accumulate; tap 0 overwrites so no clear cycle is needed
    acc_d = acc_q;
    if (vld_p1_q) begin
      acc_d = (tap_p1_q == 3'd0) ? AW'(prod_p1_q) : (acc_q + AW'(prod_p1_q));
    end
    out_data_d = out_data_q;
    if (vld_p1_q && (tap_p1_q == 3'd7)) out_data_d = round_sat(acc_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      r_q        <= 3'd0;
      k_q        <= 3'd0;
      n_q        <= 3'd0;
      mode_q     <= 1'b0;
      drain_q    <= 1'b0;
      out_addr_q <= 6'd0;
      vld_p0_q   <= 1'b0;
      tap_p0_q   <= 3'd0;
      vld_p1_q   <= 1'b0;
      tap_p1_q   <= 3'd0;
      prod_p1_q  <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      k_q        <= k_d;
      n_q        <= n_d;
      mode_q     <= mode_d;
      drain_q    <= drain_d;
      out_addr_q <= out_addr_d;
      vld_p0_q   <= vld_p0_d;
      tap_p0_q   <= tap_p0_d;
      vld_p1_q   <= vld_p1_d;
      tap_p1_q   <= tap_p1_d;
      prod_p1_q  <= prod_p1_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

endmodule
